// File: rtl/bram_fifo_ctrl.sv
// Valid/ready FIFO controller for a simple dual-port bram with one registered read port.
// Presents a first-word-fall-through stream: the bram output register holds the head word.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   synchronous clear of all contents (priority over push/pop)
//   s_valid/s_ready/s_data  upstream push interface
//   m_valid/m_ready/m_data  downstream head-word interface (m_data = bram_dout)
//   level, s_afull          words held (bram + head), almost-full flag
//   bram_we/bram_re         bram write/read enables
//   bram_waddr/bram_raddr   bram addresses, MSB tied 0
//   bram_din/bram_dout      bram write data (= s_data) / registered read data
module bram_fifo_ctrl #(
    parameter int unsigned FIFO_SIZE    = 1024,
    parameter int unsigned BIT_WIDTH    = 1024,
    parameter int unsigned AFULL_THRESH = 1020,
    localparam int unsigned AW          = $clog2(FIFO_SIZE),
    localparam int unsigned PW          = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [BIT_WIDTH-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [BIT_WIDTH-1:0] m_data,
    output logic [PW-1:0]        level,
    output logic                 s_afull,
    output logic                 bram_we,
    output logic                 bram_re,
    output logic [PW-1:0]        bram_waddr,
    output logic [PW-1:0]        bram_raddr,
    output logic [BIT_WIDTH-1:0] bram_din,
    input  logic [BIT_WIDTH-1:0] bram_dout
);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          m_valid_q, m_valid_d;

    logic [PW-1:0] stored;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    // Occupancy from full-width pointer difference; wrap bit disambiguates full vs empty.
    always_comb begin
        stored  = wptr_q - rptr_q;
        empty   = (stored == '0);
        full    = (stored == PW'(FIFO_SIZE));
        s_ready = !full;
        push    = s_valid & !full & !flush;
        pop     = m_valid_q & m_ready;
        bram_we = push;
        // Refill the head register whenever it is empty or being consumed this cycle.
        bram_re = !flush & !empty & (!m_valid_q | m_ready);
    end

    // Next-state for pointers and head-valid.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        m_valid_d = m_valid_q;
        if (flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            m_valid_d = 1'b0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (bram_re) begin
                rptr_d    = rptr_q + PW'(1);
                m_valid_d = 1'b1;
            end else if (pop) begin
                m_valid_d = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            m_valid_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            m_valid_q <= m_valid_d;
        end
    end

    // Outputs derived from registers only, so no combinational path from s_* to flags.
    always_comb begin
        m_valid    = m_valid_q;
        m_data     = bram_dout;
        level      = stored + PW'(m_valid_q);
        s_afull    = (32'(level) >= AFULL_THRESH);
        bram_waddr = {1'b0, wptr_q[AW-1:0]};
        bram_raddr = {1'b0, rptr_q[AW-1:0]};
        bram_din   = s_data;
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Testbench for bram_fifo_ctrl: directed scenarios plus random traffic, checked against a
// queue-based reference model of the FIFO (bram contents as a queue, head word as a slot).
module tb_bram_fifo_ctrl;

    localparam int unsigned FS = 4;
    localparam int unsigned BW = 8;
    localparam int unsigned AT = 4;
    localparam int unsigned PW = $clog2(FS) + 1;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [BW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [BW-1:0] m_data;
    logic [PW-1:0] level;
    logic          s_afull;
    logic          bram_we;
    logic          bram_re;
    logic [PW-1:0] bram_waddr;
    logic [PW-1:0] bram_raddr;
    logic [BW-1:0] bram_din;
    logic [BW-1:0] bram_dout;

    int vectors;
    int miscompares;

    // Reference model state
    logic [BW-1:0] q[$];
    bit            hv;
    logic [BW-1:0] hd;

    // Simple dual-port bram with registered read
    logic [BW-1:0] mem [0:FS-1];

    bram_fifo_ctrl #(
        .FIFO_SIZE   (FS),
        .BIT_WIDTH   (BW),
        .AFULL_THRESH(AT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .level     (level),
        .s_afull   (s_afull),
        .bram_we   (bram_we),
        .bram_re   (bram_re),
        .bram_waddr(bram_waddr),
        .bram_raddr(bram_raddr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_we) mem[bram_waddr[PW-2:0]] <= bram_din;
        if (bram_re) bram_dout <= mem[bram_raddr[PW-2:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        hv = 1'b0;
        hd = '0;
    endfunction

    // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic cycle();
        bit  exp_push, exp_re, exp_pop;
        int  exp_level;
        @(negedge clk);
        exp_level = q.size() + int'(hv);
        chk("s_ready", 32'(s_ready), 32'(q.size() < FS));
        chk("m_valid", 32'(m_valid), 32'(hv));
        if (hv) chk("m_data", 32'(m_data), 32'(hd));
        chk("level", 32'(level), 32'(exp_level));
        chk("s_afull", 32'(s_afull), 32'(exp_level >= AT));
        exp_push = !flush && s_valid && (q.size() < FS);
        exp_re   = !flush && (q.size() > 0) && (!hv || m_ready);
        exp_pop  = hv && m_ready;
        chk("bram_we", 32'(bram_we), 32'(exp_push));
        chk("bram_re", 32'(bram_re), 32'(exp_re));
        @(posedge clk);
        if (flush) begin
            model_reset();
        end else begin
            if (exp_re) begin
                hd = q.pop_front();
                hv = 1'b1;
            end else if (exp_pop) begin
                hv = 1'b0;
            end
            if (exp_push) q.push_back(s_data);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        m_ready     = 1'b0;
        bram_dout   = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_s_afull", 32'(s_afull), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd1);

        // 1: single word, latency 2, level 0->1->1->0
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA1;
        cycle();
        s_valid = 1'b0;
        chk("t1_level1", 32'(level), 32'd1);
        chk("t1_re", 32'(bram_re), 32'd1);
        cycle();
        chk("t1_m_valid", 32'(m_valid), 32'd1);
        chk("t1_m_data", 32'(m_data), 32'hA1);
        chk("t1_level2", 32'(level), 32'd1);
        cycle();
        chk("t1_level3", 32'(level), 32'd0);
        chk("t1_m_valid_lo", 32'(m_valid), 32'd0);
        idle(2);

        // 2: fill with m_ready low, overflow attempt, then drain
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h10 + i);
            cycle();
        end
        chk("t2_level", 32'(level), 32'd5);
        chk("t2_s_ready", 32'(s_ready), 32'd0);
        chk("t2_s_afull", 32'(s_afull), 32'd1);
        s_valid = 1'b0;
        m_ready = 1'b1;
        idle(7);

        // 3: streaming 0..19 with both sides always ready
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            cycle();
            chk("t3_level_le2", 32'(level <= 2), 32'd1);
        end
        s_valid = 1'b0;
        idle(3);

        // 4: backpressure toggle with FIFO half full
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'hC0 + i);
            cycle();
        end
        s_valid = 1'b0;
        for (int r = 0; r < 3; r++) begin
            m_ready = 1'b1; cycle();
            m_ready = 1'b0; cycle();
            m_ready = 1'b0; cycle();
            m_ready = 1'b1; cycle();
        end
        idle(2);

        // 5: flush at level 3 with head valid
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h30 + i);
            cycle();
        end
        s_valid = 1'b0;
        chk("t5_pre_level", 32'(level), 32'd3);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("t5_m_valid", 32'(m_valid), 32'd0);
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_s_ready", 32'(s_ready), 32'd1);
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h77;
        cycle();
        s_valid = 1'b0;
        cycle();
        chk("t5_first", 32'(m_data), 32'h77);
        idle(2);

        // 6: async reset mid-stream
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h60 + i);
            cycle();
        end
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_m_valid", 32'(m_valid), 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_s_afull", 32'(s_afull), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        cycle();
        s_valid = 1'b0;
        chk("t6_re", 32'(bram_re), 32'd1);
        cycle();
        chk("t6_m_valid_hi", 32'(m_valid), 32'd1);
        chk("t6_m_data", 32'(m_data), 32'h5A);
        idle(2);

        // Random traffic with occasional flush
        for (int i = 0; i < 600; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
            flush   = ($urandom_range(0, 40) == 0);
            cycle();
        end
        flush   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        idle(8);
        chk("final_level", 32'(level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
